// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and constants for the serial receive path
// Holds the receive FSM state encoding and the divider constants that the
// tick generator and the receive sequencer must agree on.
package serial_pkg;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    localparam int DATA_BITS_DEF  = 8;
    localparam int FAST_TICKS_DEF = 4;

    // 50 MHz / 9600 baud, and the quarter-bit divider used while hunting
    localparam int BAUD_DIV = 5208;
    localparam int FAST_DIV = 1302;

endpackage

// File: rtl/serial_rx_ctrl_if.sv
// rtl/serial_rx_ctrl_if.sv - received-byte valid/ready handshake bundle
// Ports (signals):
//   rx_data  : received byte, stable while rx_valid
//   rx_valid : byte available, held until accepted
//   rx_ready : consumer accepts when rx_valid && rx_ready
// master = receiver side, slave = consumer side.
interface serial_rx_ctrl_if #(
    parameter int DATA_BITS = 8
) ();

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );

endinterface

// File: rtl/serial_sync2.sv
// rtl/serial_sync2.sv - two-flop synchronizer with configurable reset value
// Ports:
//   clk_50 : system clock
//   RESET  : synchronous active-high reset, loads RESET_VAL into both flops
//   d      : asynchronous input
//   q      : synchronized output
module serial_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_50,
    input  logic RESET,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk_50) begin
        if (RESET) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial_rx_ctrl.sv
// rtl/serial_rx_ctrl.sv - UART receive sequencer driving an external tick generator
// Hunts for a start bit at fast-tick resolution, re-phases the tick generator
// to the start-bit centre, samples data and stop bits once per bit and hands
// bytes out over a valid/ready handshake.
// Optional feature macro: SERIAL_RX_PARITY_EN (adds an even-parity bit).
// Ports:
//   clk_50, RESET : clock, synchronous active-high reset
//   rx            : asynchronous serial line, idle high
//   sample_tick   : one-cycle tick from the tick generator
//   rate_sel      : 0 = fast ticks (start hunt), 1 = one tick per bit
//   tick_sync     : one-cycle pulse restarting the tick generator divider
//   rx_if         : rx_data / rx_valid / rx_ready handshake (master)
//   frame_err     : sticky, bad stop bit (or bad parity)
//   overrun       : sticky, frame completed while a byte was still pending
//   err_clr       : clears frame_err and overrun, wins over a same-cycle set
module serial_rx_ctrl
    import serial_pkg::*;
#(
    parameter int DATA_BITS          = DATA_BITS_DEF,
    parameter int FAST_TICKS_PER_BIT = FAST_TICKS_DEF
) (
    input  logic                    clk_50,
    input  logic                    RESET,
    input  logic                    rx,
    input  logic                    sample_tick,
    output logic                    rate_sel,
    output logic                    tick_sync,
    serial_rx_ctrl_if.master        rx_if,
    output logic                    frame_err,
    output logic                    overrun,
    input  logic                    err_clr
);

    localparam int QW = $clog2(FAST_TICKS_PER_BIT) + 1;
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [QW-1:0] Q_ONE  = QW'(1);
    localparam logic [QW-1:0] Q_HALF = QW'(FAST_TICKS_PER_BIT / 2);
    localparam logic [BW-1:0] B_ONE  = BW'(1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    localparam logic [2:0] ST_IDLE   = RX_IDLE;
    localparam logic [2:0] ST_START  = RX_START;
    localparam logic [2:0] ST_DATA   = RX_DATA;
    localparam logic [2:0] ST_STOP   = RX_STOP;
`ifdef SERIAL_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = RX_PARITY;
`endif

    logic                 rxs;
    logic [2:0]           state;
    logic [QW-1:0]        qcnt;
    logic [BW-1:0]        bcnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err;
    logic                 tick;
    logic                 slot_free;

    serial_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk_50 (clk_50),
        .RESET  (RESET),
        .d      (rx),
        .q      (rxs)
    );

    // The generator is being restarted in the tick_sync cycle, so a tick
    // that lands there belongs to the old phase and is dropped.
    assign tick = sample_tick & ~tick_sync;

    // An accept in the same cycle frees the slot, so a new byte may load
    // over it instead of counting as an overrun.
    assign slot_free = ~rx_if.rx_valid | rx_if.rx_ready;

`ifndef SERIAL_RX_PARITY_EN
    assign par_err = 1'b0;
`endif

    always_ff @(posedge clk_50) begin
        if (RESET) begin
            state          <= ST_IDLE;
            qcnt           <= '0;
            bcnt           <= '0;
            shreg          <= '0;
            rate_sel       <= 1'b0;
            tick_sync      <= 1'b0;
            rx_if.rx_data  <= '0;
            rx_if.rx_valid <= 1'b0;
            frame_err      <= 1'b0;
            overrun        <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_err        <= 1'b0;
`endif
        end else begin
            tick_sync <= 1'b0;

            if (rx_if.rx_valid && rx_if.rx_ready) begin
                rx_if.rx_valid <= 1'b0;
            end

            if (tick) begin
                case (state)
                    ST_IDLE: begin
                        if (!rxs) begin
                            state <= ST_START;
                            qcnt  <= Q_ONE;
                        end
                    end
                    ST_START: begin
                        if (rxs) begin
                            state <= ST_IDLE;
                        end else begin
                            qcnt <= qcnt + Q_ONE;
                            // Half a bit of continuous low: we are at the
                            // start-bit centre, so re-phase to bit rate here.
                            if ((qcnt + Q_ONE) >= Q_HALF) begin
                                tick_sync <= 1'b1;
                                rate_sel  <= 1'b1;
                                bcnt      <= '0;
                                state     <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        shreg <= {rxs, shreg[DATA_BITS-1:1]};
                        bcnt  <= bcnt + B_ONE;
                        if (bcnt == B_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end
`ifdef SERIAL_RX_PARITY_EN
                    ST_PARITY: begin
                        // Even parity: data bits plus parity bit XOR to 0.
                        par_err <= ^{shreg, rxs};
                        state   <= ST_STOP;
                    end
`endif
                    ST_STOP: begin
                        if (rxs && !par_err) begin
                            if (slot_free) begin
                                rx_if.rx_data  <= shreg;
                                rx_if.rx_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                        tick_sync <= 1'b1;
                        rate_sel  <= 1'b0;
                        state     <= ST_IDLE;
                    end
                    default: begin
                        state    <= ST_IDLE;
                        rate_sel <= 1'b0;
                    end
                endcase
            end

            // Last assignment wins, giving the clear priority over any set.
            if (err_clr) begin
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_rx_ctrl.sv
// tb/tb_serial_rx_ctrl.sv - self-checking bench for serial_rx_ctrl
module tb_serial_rx_ctrl;

    logic clk_50      = 1'b0;
    logic RESET       = 1'b1;
    logic rx          = 1'b1;
    logic sample_tick = 1'b0;
    logic err_clr     = 1'b0;
    logic rate_sel;
    logic tick_sync;
    logic frame_err;
    logic overrun;

    serial_rx_ctrl_if #(.DATA_BITS(8)) rx_if ();

    serial_rx_ctrl #(
        .DATA_BITS          (8),
        .FAST_TICKS_PER_BIT (4)
    ) dut (
        .clk_50      (clk_50),
        .RESET       (RESET),
        .rx          (rx),
        .sample_tick (sample_tick),
        .rate_sel    (rate_sel),
        .tick_sync   (tick_sync),
        .rx_if       (rx_if.master),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .err_clr     (err_clr)
    );

    always #10 clk_50 = ~clk_50;

    // Tick generator stand-in: fast tick every 4 cycles, bit tick every 16.
    int tcnt = 0;
    always @(negedge clk_50) begin
        if (RESET || tick_sync) begin
            tcnt        = 0;
            sample_tick = 1'b0;
        end else if (tcnt >= (rate_sel ? 15 : 3)) begin
            tcnt        = 0;
            sample_tick = 1'b1;
        end else begin
            tcnt        = tcnt + 1;
            sample_tick = 1'b0;
        end
    end

    // Behavioural model: bytes owed to the consumer, in order, plus flags.
    logic [7:0] exp_q[$];
    bit         occupied = 1'b0;
    bit         m_fe     = 1'b0;
    bit         m_ovr    = 1'b0;

    int checks = 0;
    int errors = 0;

    int         ts_count     = 0;
    int         valid_cycles = 0;
    int         rs_cycles    = 0;
    logic [7:0] last_acc     = 8'h00;
    bit         prev_hold    = 1'b0;
    logic [7:0] prev_data    = 8'h00;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Compare process: every accepted byte must be the oldest owed byte, and
    // a held byte must not change.
    always @(negedge clk_50) begin
        if (!RESET) begin
            if (prev_hold && rx_if.rx_valid) begin
                chk("hold_stable", {24'h0, rx_if.rx_data}, {24'h0, prev_data});
            end
            if (rx_if.rx_valid && rx_if.rx_ready) begin
                checks = checks + 1;
                if (exp_q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL accept_unexpected got %0h expected none", rx_if.rx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (rx_if.rx_data !== e) begin
                        errors = errors + 1;
                        $display("FAIL accept_data got %0h expected %0h", rx_if.rx_data, e);
                    end
                end
                last_acc = rx_if.rx_data;
            end
            if (tick_sync)      ts_count     = ts_count + 1;
            if (rx_if.rx_valid) valid_cycles = valid_cycles + 1;
            if (rate_sel)       rs_cycles    = rs_cycles + 1;
            prev_hold = rx_if.rx_valid && !rx_if.rx_ready;
            prev_data = rx_if.rx_data;
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_50);
        #2;
    endtask

    task automatic set_ready(input bit r);
        rx_if.rx_ready = r;
        if (r) occupied = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_frame_err"}, {31'h0, frame_err}, {31'h0, m_fe});
        chk({tag, "_overrun"}, {31'h0, overrun}, {31'h0, m_ovr});
        chk({tag, "_rx_valid"}, {31'h0, rx_if.rx_valid}, {31'h0, occupied});
        chk({tag, "_rate_sel"}, {31'h0, rate_sel}, 32'h0);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                              input bit par_bad, input bit ready, input int gap);
        int ts0;
        set_ready(ready);
        cyc(4 + gap);
        ts0 = ts_count;
        rx = 1'b0;
        cyc(16);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cyc(16);
        end
`ifdef SERIAL_RX_PARITY_EN
        rx = (^b) ^ par_bad;
        cyc(16);
`endif
        if (stop_ok && !par_bad) begin
            if (occupied && !ready) begin
                m_ovr = 1'b1;
            end else begin
                exp_q.push_back(b);
                occupied = !ready;
            end
        end else begin
            m_fe = 1'b1;
        end
        if (stop_ok) begin
            rx = 1'b1;
            cyc(16);
        end else begin
            // Low only around the sample point, so the tail is not a new start.
            rx = 1'b0;
            cyc(9);
            rx = 1'b1;
            cyc(7);
        end
        cyc(6);
        check_idle("frame");
        chk("frame_tick_syncs", ts_count - ts0, 32'd2);
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        m_fe  = 1'b0;
        m_ovr = 1'b0;
        cyc(1);
        chk("clr_frame_err", {31'h0, frame_err}, 32'h0);
        chk("clr_overrun", {31'h0, overrun}, 32'h0);
    endtask

    task automatic check_reset_values();
        chk("rst_rate_sel", {31'h0, rate_sel}, 32'h0);
        chk("rst_tick_sync", {31'h0, tick_sync}, 32'h0);
        chk("rst_rx_data", {24'h0, rx_if.rx_data}, 32'h0);
        chk("rst_rx_valid", {31'h0, rx_if.rx_valid}, 32'h0);
        chk("rst_frame_err", {31'h0, frame_err}, 32'h0);
        chk("rst_overrun", {31'h0, overrun}, 32'h0);
    endtask

    initial begin
        int v0, t0, r0;
        rx_if.rx_ready = 1'b1;
        cyc(3);
        RESET = 1'b0;
        cyc(1);
        check_reset_values();

        // Clean frame, consumer ready: one-cycle valid pulse.
        v0 = valid_cycles;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 3);
        chk("a5_data", {24'h0, last_acc}, 32'hA5);
        chk("a5_valid_width", valid_cycles - v0, 32'd1);

        // One-fast-tick glitch must be rejected.
        t0 = ts_count; r0 = rs_cycles; v0 = valid_cycles;
        cyc(5);
        rx = 1'b0;
        cyc(4);
        rx = 1'b1;
        cyc(30);
        chk("glitch_tick_sync", ts_count - t0, 32'd0);
        chk("glitch_rate_sel", rs_cycles - r0, 32'd0);
        chk("glitch_valid", valid_cycles - v0, 32'd0);

        // Bad stop bit.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1);
        chk("3c_frame_err", {31'h0, frame_err}, 32'h1);
        pulse_err_clr();

        // Overrun: second byte dropped while first is held.
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, 2);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, 0);
        chk("ovr_data", {24'h0, rx_if.rx_data}, 32'h11);
        chk("ovr_flag", {31'h0, overrun}, 32'h1);
        set_ready(1'b1);
        cyc(3);
        chk("ovr_drain_valid", {31'h0, rx_if.rx_valid}, 32'h0);
        chk("ovr_drain_data", {24'h0, last_acc}, 32'h11);
        pulse_err_clr();

        // Reset after the 4th data bit.
        cyc(7);
        rx = 1'b0;
        cyc(16);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            cyc(16);
        end
        chk("pre_reset_rate_sel", {31'h0, rate_sel}, 32'h1);
        RESET = 1'b1;
        rx    = 1'b1;
        cyc(1);
        RESET = 1'b0;
        exp_q.delete();
        occupied = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
        cyc(1);
        check_reset_values();
        send_frame(8'h7E, 1'b1, 1'b0, 1'b1, 5);
        chk("7e_data", {24'h0, last_acc}, 32'h7E);

`ifdef SERIAL_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 2);
        chk("par_bad_frame_err", {31'h0, frame_err}, 32'h1);
        pulse_err_clr();
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 2);
        chk("par_ok_data", {24'h0, last_acc}, 32'h07);
`endif

        // Randomized frames against the model.
        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            bit sok, pb, rdy;
            b   = 8'($urandom);
            sok = ($urandom_range(0, 4) != 0);
`ifdef SERIAL_RX_PARITY_EN
            pb  = ($urandom_range(0, 5) == 0);
`else
            pb  = 1'b0;
`endif
            rdy = $urandom_range(0, 1) == 1;
            send_frame(b, sok, pb, rdy, $urandom_range(0, 20));
            if ($urandom_range(0, 3) == 0) pulse_err_clr();
        end

        set_ready(1'b1);
        cyc(5);
        chk("final_queue_empty", exp_q.size(), 32'd0);
        chk("final_valid", {31'h0, rx_if.rx_valid}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
